// File: rtl/apple1_pkg.sv
// apple1_pkg: PS/2 set-2 scancodes, Apple-1 ASCII constants, receiver states and the scancode-to-ASCII map.
package apple1_pkg;
  localparam logic [7:0] SC_BREAK = 8'hF0, SC_EXT = 8'hE0, SC_LSHIFT = 8'h12, SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL = 8'h14, SC_ENTER = 8'h5A, SC_BKSP = 8'h66, SC_ESC = 8'h76;
  localparam logic [7:0] ASC_CR = 8'h0D, ASC_RUBOUT = 8'h5F, ASC_ESC = 8'h1B;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;
  // Zero means "no key": nothing mapped here translates to NUL.
  function automatic logic [7:0] sc_to_ascii(input logic [7:0] sc, input logic shift);
    case (sc)
      8'h1C: return 8'h41; 8'h32: return 8'h42; 8'h21: return 8'h43; 8'h23: return 8'h44;
      8'h24: return 8'h45; 8'h2B: return 8'h46; 8'h34: return 8'h47; 8'h33: return 8'h48;
      8'h43: return 8'h49; 8'h3B: return 8'h4A; 8'h42: return 8'h4B; 8'h4B: return 8'h4C;
      8'h3A: return 8'h4D; 8'h31: return 8'h4E; 8'h44: return 8'h4F; 8'h4D: return 8'h50;
      8'h15: return 8'h51; 8'h2D: return 8'h52; 8'h1B: return 8'h53; 8'h2C: return 8'h54;
      8'h3C: return 8'h55; 8'h2A: return 8'h56; 8'h1D: return 8'h57; 8'h22: return 8'h58;
      8'h35: return 8'h59; 8'h1A: return 8'h5A;
      8'h16: return shift ? 8'h21 : 8'h31;
      8'h1E: return shift ? 8'h40 : 8'h32;
      8'h26: return shift ? 8'h23 : 8'h33;
      8'h25: return shift ? 8'h24 : 8'h34;
      8'h2E: return shift ? 8'h25 : 8'h35;
      8'h36: return shift ? 8'h5E : 8'h36;
      8'h3D: return shift ? 8'h26 : 8'h37;
      8'h3E: return shift ? 8'h2A : 8'h38;
      8'h46: return shift ? 8'h28 : 8'h39;
      8'h45: return shift ? 8'h29 : 8'h30;
      8'h0E: return shift ? 8'h7E : 8'h60;
      8'h4E: return shift ? 8'h5F : 8'h2D;
      8'h55: return shift ? 8'h2B : 8'h3D;
      8'h54: return shift ? 8'h7B : 8'h5B;
      8'h5B: return shift ? 8'h7D : 8'h5D;
      8'h5D: return shift ? 8'h7C : 8'h5C;
      8'h4C: return shift ? 8'h3A : 8'h3B;
      8'h52: return shift ? 8'h22 : 8'h27;
      8'h41: return shift ? 8'h3C : 8'h2C;
      8'h49: return shift ? 8'h3E : 8'h2E;
      8'h4A: return shift ? 8'h3F : 8'h2F;
      SC_ENTER: return ASC_CR;
      SC_BKSP: return ASC_RUBOUT;
      SC_ESC: return ASC_ESC;
      8'h29: return 8'h20;
      default: return 8'h00;
    endcase
  endfunction
endpackage

// File: rtl/ps2_rx.sv
// ps2_rx: synchronises and glitch-filters the PS/2 lines and receives one 11-bit frame,
// emitting the byte with a one-cycle valid or a one-cycle err.
module ps2_rx
  import apple1_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 25000,
  parameter int FILTER_LEN = 8
) (
  input  logic       clk25,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data,
  output logic       valid,
  output logic       err
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [1:0] clk_s, dat_s;
  logic filt, filt_d, fall;
  logic [FW-1:0] fcnt;
  logic [TW-1:0] tcnt;
  logic [2:0] bits;
  rx_state_t state;
  assign fall = filt_d & ~filt;
  always_ff @(posedge clk25 or negedge rst_n)
    if (!rst_n) begin
      clk_s <= '1;
      dat_s <= '1;
      filt <= 1'b1;
      filt_d <= 1'b1;
      fcnt <= '0;
      tcnt <= '0;
      bits <= '0;
      data <= '0;
      state <= IDLE;
      valid <= 1'b0;
      err <= 1'b0;
    end else begin
      clk_s <= {clk_s[0], ps2_clk};
      dat_s <= {dat_s[0], ps2_data};
      filt_d <= filt;
      // The filtered clock only moves after FILTER_LEN consecutive samples disagree with it.
      if (clk_s[1] == filt) fcnt <= '0;
      else if (fcnt == FW'(FILTER_LEN - 1)) begin
        filt <= clk_s[1];
        fcnt <= '0;
      end else fcnt <= fcnt + 1'b1;
      valid <= 1'b0;
      err <= 1'b0;
      tcnt <= (state == IDLE || fall) ? '0 : tcnt + 1'b1;
      if (fall)
        case (state)
          IDLE: if (!dat_s[1]) begin
            state <= DATA;
            bits <= '0;
          end
          DATA: begin
            data <= {dat_s[1], data[7:1]};
            bits <= bits + 1'b1;
            if (bits == 3'd7) state <= PARITY;
          end
          PARITY: if (^{dat_s[1], data}) state <= STOP;
          else begin
            err <= 1'b1;
            state <= IDLE;
          end
          STOP: begin
            state <= IDLE;
            valid <= dat_s[1];
            err <= !dat_s[1];
          end
        endcase
      else if (state != IDLE && tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
        err <= 1'b1;
        state <= IDLE;
      end
    end
endmodule

// File: rtl/ps2_keyboard.sv
// ps2_keyboard: PS/2 keyboard to Apple-1 keyboard register, with modifier tracking,
// ASCII translation and a read/overrun handshake.
module ps2_keyboard
  import apple1_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 25000,
  parameter int FILTER_LEN = 8
) (
  input  logic       clk25,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       kbd_rd,
  output logic [7:0] kbd_data,
  output logic       kbd_ready,
  output logic       overrun,
  output logic       frame_err
);
  logic [7:0] rx_data, asc, ch;
  logic rx_valid, key, brk, ext, lshift, rshift, ctrl;
  ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .FILTER_LEN(FILTER_LEN)) u_rx (
    .clk25(clk25), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .data(rx_data), .valid(rx_valid), .err(frame_err)
  );
  always_comb begin
    asc = sc_to_ascii(rx_data, lshift | rshift);
    ch = (ctrl && asc >= 8'h41 && asc <= 8'h5A) ? (asc & 8'h1F) : asc;
    key = rx_valid && !brk && !ext && asc != 8'h00;
  end
  always_ff @(posedge clk25 or negedge rst_n)
    if (!rst_n) begin
      {brk, ext, lshift, rshift, ctrl} <= '0;
      kbd_data <= 8'h80;
      kbd_ready <= 1'b0;
      overrun <= 1'b0;
    end else begin
      // Prefixes accumulate until a non-prefix byte consumes them.
      if (rx_valid) begin
        brk <= (rx_data == SC_BREAK) || (rx_data == SC_EXT && brk);
        ext <= (rx_data == SC_EXT) || (rx_data == SC_BREAK && ext);
        if (rx_data == SC_LSHIFT) lshift <= !brk;
        if (rx_data == SC_RSHIFT) rshift <= !brk;
        if (rx_data == SC_CTRL) ctrl <= !brk;
      end
      if (kbd_rd) kbd_ready <= 1'b0;
      if (key) begin
        if (kbd_ready && !kbd_rd) overrun <= 1'b1;
        else begin
          kbd_data <= {1'b1, ch[6:0]};
          kbd_ready <= 1'b1;
        end
      end
    end
endmodule

// File: doc/ps2_keyboard.md
PS2_KEYBOARD -- requirements
Module: ps2_keyboard

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 25000, max clk25 cycles between PS/2 falling edges inside a frame (1 ms).
REQ-002 SHALL have parameter FILTER_LEN, default 8, consecutive equal samples needed to accept a ps2_clk level change.
REQ-003 SHALL have port clk25  in  1  25 MHz master clock, the block's only clock.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port ps2_clk  in  1  PS/2 clock from keyboard, asynchronous.
REQ-006 SHALL have port ps2_data  in  1  PS/2 data from keyboard, asynchronous.
REQ-007 SHALL have port kbd_rd  in  1  one-cycle strobe: consumer has read kbd_data.
REQ-008 SHALL have port kbd_data  out  8  {1'b1, 7-bit ASCII}, Apple-1 keyboard register format.
REQ-009 SHALL have port kbd_ready  out  1  key available, held until kbd_rd.
REQ-010 SHALL have port overrun  out  1  sticky: key dropped while kbd_ready=1.
REQ-011 SHALL have port frame_err  out  1  one-cycle pulse on parity, start, stop or timeout error.

Function
REQ-012 SHALL synchronise ps2_clk and ps2_data through 2 flops each, then glitch-filter ps2_clk with FILTER_LEN samples.
REQ-013 SHALL sample ps2_data on each filtered ps2_clk falling edge.
REQ-014 Receiver FSM SHALL use states IDLE, DATA, PARITY, STOP; IDLE->DATA on edge with data=0; data=1 in IDLE ignored.
REQ-015 DATA SHALL shift 8 bits LSB first, then ->PARITY; PARITY checks odd parity ->STOP; STOP requires data=1 ->IDLE.
REQ-016 Parity or stop failure SHALL discard the byte, pulse frame_err, return to IDLE.
REQ-017 No edge for TIMEOUT_CYCLES outside IDLE SHALL discard, pulse frame_err, return to IDLE.
REQ-018 Decoder SHALL treat 0xF0 as break prefix and 0xE0 as extended prefix, each applying to the next byte only.
REQ-019 Decoder SHALL track make/break of 0x12/0x59 (shift) and 0x14 (ctrl); modifiers alone SHALL produce no key.
REQ-020 Letters SHALL map to uppercase ASCII 0x41-0x5A regardless of shift; digits/punctuation use shifted US map when shift held.
REQ-021 0x5A (Enter) SHALL map to 0x0D, 0x66 (Backspace) to 0x5F, 0x76 (Esc) to 0x1B, 0x29 (Space) to 0x20.
REQ-022 Ctrl+letter SHALL produce letter AND 0x1F; unmapped codes, break codes, E0-prefixed keys SHALL produce no key.
REQ-023 kbd_ready SHALL rise exactly 2 clk25 cycles after the filtered falling edge accepting a valid stop bit, with kbd_data valid the same cycle.
REQ-024 kbd_rd SHALL clear kbd_ready next cycle; kbd_rd with kbd_ready=0 SHALL have no effect.
REQ-025 New key while kbd_ready=1 and no kbd_rd that cycle SHALL be dropped, kbd_data kept, overrun set.
REQ-026 New key and kbd_rd in same cycle SHALL load new kbd_data and keep kbd_ready=1, no overrun.
REQ-027 overrun SHALL clear only on reset.

Reset
REQ-028 rst_n low SHALL asynchronously force FSM to IDLE, shift/ctrl/prefix flags clear, synchronisers/filter to 1, timeout counter 0.
REQ-029 Reset values SHALL be kbd_data=0x80, kbd_ready=0, overrun=0, frame_err=0.
REQ-030 Reset mid-frame SHALL discard the partial frame; the next frame after release SHALL decode normally.

Structure
REQ-031 Shared package apple1_pkg SHALL hold scancode constants (SC_BREAK, SC_EXT, SC_LSHIFT, SC_RSHIFT, SC_CTRL, SC_ENTER, SC_BKSP, SC_ESC) and ASCII constants (ASC_CR, ASC_RUBOUT, ASC_ESC).
REQ-032 Frame reception (REQ-012..017) SHALL be sub-module ps2_rx outputting byte plus one-cycle valid; translation and handshake stay in ps2_keyboard.

Verification
REQ-033 Frame 0x1C, ps2_clk 12.5 kHz -> kbd_data=0xC1, kbd_ready=1 at edge+2 cycles; kbd_rd -> kbd_ready=0 next cycle.
REQ-034 Sequence 12,16,F0,16,F0,12 -> one key 0xA1 ('!'); break codes produce no key.
REQ-035 0x1C with parity bit wrong -> frame_err pulse, kbd_ready stays 0; next valid 0x5A -> kbd_data=0x8D.
REQ-036 Two keys 0x1C,0x32 without kbd_rd -> kbd_data=0xC1, overrun=1; second key with kbd_rd coincident -> kbd_data=0xC2, overrun=0.
REQ-037 Stop ps2_clk after 4 data bits for 30000 cycles -> frame_err pulse, FSM IDLE; then 0x66 -> kbd_data=0xDF.
REQ-038 rst_n low mid-frame after 5 bits -> kbd_data=0x80, kbd_ready=0 immediately; following frame 0x14,0x21 -> kbd_data=0x83.
